if_id_fetch_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode and the load-use hazard detection unit.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Consumes the hazard unit's `stall` to freeze IF/ID, and the EX-stage branch redirect to flush it.
- Produces `if_id_pc`, `if_id_instr` and `if_id_valid` for decode.

---
 rtl/if_id_fetch_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register. Keeps the PC, issues
//   single-outstanding requests to instruction memory, and loads the fetched
//   word into IF/ID for decode. Honours the hazard unit's stall (freeze IF/ID
//   and PC) and the EX-stage branch redirect (flush IF/ID, reload PC).
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   stall                        1 = hold IF/ID and PC
//   branch_taken, branch_target  redirect from EX (target bits [1:0] ignored)
//   imem_req, imem_addr          one-cycle request strobe and fetch address
//   imem_rvalid, imem_rdata      response strobe and instruction word
//   if_id_pc/instr/valid         IF/ID contents presented to decode
//   dbg_state                    current FSM state (IDLE=0 REQ=1 WAIT=2 HOLD=3)
//
// Handshake: the request side is a strobe the memory always accepts; the
// response side is a strobe with no back-pressure. Only one request is ever
// outstanding, so a response always belongs to the most recent request.
// ---------------------------------------------------------------------------
module if_id_fetch_stage #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic              drop_q, drop_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            drop_q        <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            drop_q        <= drop_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        drop_d        = drop_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid && drop_q) begin
                    // Response to a request issued before a redirect: pc
                    // already holds the target, so just re-issue.
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                    if (!stall) begin
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end
                end else if (imem_rvalid && !stall) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_plus4;
                    state_d       = S_REQ;
                end else if (imem_rvalid) begin
                    // Memory cannot be back-pressured: park the word.
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = pc_q;
                    state_d      = S_HOLD;
                end else if (!stall) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    if_id_pc_d    = skid_pc_q;
                    if_id_instr_d = skid_instr_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_plus4;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above, including stall.
        if (branch_taken) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            pc_d          = {branch_target[XLEN-1:2], 2'b00};
            skid_instr_d  = NOP_INSTR;
            state_d       = S_REQ;
            drop_d        = 1'b0;
            // A request for the old pc is in flight: its response must be
            // thrown away before fetching the target.
            if (state_q == S_REQ || (state_q == S_WAIT && !imem_rvalid)) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign dbg_state   = state_q;

endmodule
